// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the single-precision FP issue controller.
// Holds the decoded-op enum, the OP-FP opcode, funct7 groups and FSM encoding.
package fp_ctrl_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_MUL  = 4'd3,
      OP_DIV  = 4'd4,
      OP_SQRT = 4'd5,
      OP_MIN  = 4'd6,
      OP_MAX  = 4'd7,
      OP_EQ   = 4'd8,
      OP_LT   = 4'd9,
      OP_LE   = 4'd10
   } fp_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WB    = 2'd3
   } fsm_state_t;

   localparam logic [6:0] OPCODE_OPFP = 7'b1010011;

   localparam logic [6:0] F7_ADD    = 7'b0000000;
   localparam logic [6:0] F7_SUB    = 7'b0000100;
   localparam logic [6:0] F7_MUL    = 7'b0001000;
   localparam logic [6:0] F7_DIV    = 7'b0001100;
   localparam logic [6:0] F7_SQRT   = 7'b0101100;
   localparam logic [6:0] F7_MINMAX = 7'b0010100;
   localparam logic [6:0] F7_CMP    = 7'b1010000;

   // Rounding-mode encodings 101 and 110 are reserved; 111 (dynamic) passes through.
   function automatic logic rm_reserved(input logic [2:0] rm);
      return (rm == 3'b101) || (rm == 3'b110);
   endfunction

endpackage

// File: rtl/fp_instr_decode.sv
// Combinational decoder for OP-FP single-precision instructions.
// Produces the op class, an illegal flag and whether the result goes to the integer file.
module fp_instr_decode
   import fp_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output fp_op_t      op,
   output logic        illegal,
   output logic        is_cmp
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic [4:0] rs2;
   logic       unused_fields;

   assign opcode        = instr[6:0];
   assign funct3        = instr[14:12];
   assign rs2           = instr[24:20];
   assign funct7        = instr[31:25];
   assign unused_fields = ^{instr[19:15], instr[11:7]};

   // Map funct7/funct3/rs2 to an op class; anything unmatched stays illegal.
   always_comb begin
      op      = OP_NOP;
      illegal = 1'b1;
      is_cmp  = 1'b0;
      if (opcode == OPCODE_OPFP) begin
         case (funct7)
            F7_ADD:  begin op = OP_ADD; illegal = rm_reserved(funct3); end
            F7_SUB:  begin op = OP_SUB; illegal = rm_reserved(funct3); end
            F7_MUL:  begin op = OP_MUL; illegal = rm_reserved(funct3); end
            F7_DIV:  begin op = OP_DIV; illegal = rm_reserved(funct3); end
            F7_SQRT: begin
               op      = OP_SQRT;
               illegal = rm_reserved(funct3) || (rs2 != 5'd0);
            end
            F7_MINMAX: begin
               case (funct3)
                  3'b000:  begin op = OP_MIN; illegal = 1'b0; end
                  3'b001:  begin op = OP_MAX; illegal = 1'b0; end
                  default: ;
               endcase
            end
            F7_CMP: begin
               is_cmp = 1'b1;
               case (funct3)
                  3'b010:  begin op = OP_EQ; illegal = 1'b0; end
                  3'b001:  begin op = OP_LT; illegal = 1'b0; end
                  3'b000:  begin op = OP_LE; illegal = 1'b0; end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
      if (illegal) begin
         op     = OP_NOP;
         is_cmp = 1'b0;
      end
   end

endmodule

// File: rtl/fp_issue_ctrl.sv
// Issue/sequencing controller in front of the single-precision FP datapath.
// Accepts one instruction at a time, starts the FPU, times the op and strobes writeback.
// Optional performance counters are built when FP_PERF_CNT_EN is defined.
//
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready
// are both 1 and flush is 0; in_ready depends only on state, never on in_valid,
// and the offerer must hold instr stable while in_valid is 1 and in_ready is 0.
module fp_issue_ctrl
   import fp_ctrl_pkg::*;
#(
   parameter int LAT_ADD  = 3,
   parameter int LAT_MUL  = 4,
   parameter int LAT_DIV  = 12,
   parameter int LAT_SQRT = 12,
   parameter int LAT_CMP  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic        flush,
   output logic        fpu_start,
   output logic [3:0]  fpu_op,
   output logic [4:0]  fpu_rs1,
   output logic [4:0]  fpu_rs2,
   output logic [2:0]  fpu_rm,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_int,
   output logic        illegal,
   output logic        busy,
   output logic [1:0]  dbg_state
`ifdef FP_PERF_CNT_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_busy,
   output logic [15:0] perf_illegal
`endif
);

   fsm_state_t state;
   fp_op_t     op_q;
   logic [4:0] cnt;
   logic       is_cmp_q;

   fp_op_t     dec_op;
   logic       dec_illegal;
   logic       dec_is_cmp;

   fp_instr_decode u_decode (
      .instr   (instr),
      .op      (dec_op),
      .illegal (dec_illegal),
      .is_cmp  (dec_is_cmp)
   );

   // Counter preload is LAT-1 so WAIT spends exactly LAT cycles.
   function automatic logic [4:0] lat_m1(input fp_op_t op);
      logic [4:0] r;
      case (op)
         OP_ADD, OP_SUB: r = 5'(LAT_ADD - 1);
         OP_MUL:         r = 5'(LAT_MUL - 1);
         OP_DIV:         r = 5'(LAT_DIV - 1);
         OP_SQRT:        r = 5'(LAT_SQRT - 1);
         default:        r = 5'(LAT_CMP - 1);
      endcase
      return r;
   endfunction

   assign in_ready  = (state == ST_IDLE) || (state == ST_WB);
   assign busy      = (state == ST_START) || (state == ST_WAIT);
   assign fpu_op    = op_q;
   assign dbg_state = state;

   // Issue FSM with registered pulses; rst beats flush, flush beats accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= OP_NOP;
         fpu_rs1   <= 5'd0;
         fpu_rs2   <= 5'd0;
         fpu_rm    <= 3'd0;
         wb_rd     <= 5'd0;
         is_cmp_q  <= 1'b0;
         cnt       <= 5'd0;
         fpu_start <= 1'b0;
         wb_valid  <= 1'b0;
         wb_int    <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         fpu_start <= 1'b0;
         wb_valid  <= 1'b0;
         wb_int    <= 1'b0;
         illegal   <= 1'b0;
         if (flush) begin
            // Flush in IDLE only blocks the accept; otherwise the op is abandoned.
            if (state != ST_IDLE) begin
               state   <= ST_IDLE;
               op_q    <= OP_NOP;
               fpu_rs1 <= 5'd0;
               fpu_rs2 <= 5'd0;
               fpu_rm  <= 3'd0;
               cnt     <= 5'd0;
            end
         end else begin
            case (state)
               ST_IDLE, ST_WB: begin
                  state <= ST_IDLE;
                  if (in_valid) begin
                     if (dec_illegal) begin
                        illegal <= 1'b1;
                     end else begin
                        state    <= ST_START;
                        op_q     <= dec_op;
                        fpu_rs1  <= instr[19:15];
                        fpu_rs2  <= instr[24:20];
                        fpu_rm   <= instr[14:12];
                        wb_rd    <= instr[11:7];
                        is_cmp_q <= dec_is_cmp;
                     end
                  end
               end
               ST_START: begin
                  fpu_start <= 1'b1;
                  cnt       <= lat_m1(op_q);
                  state     <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (cnt == 5'd0) begin
                     state    <= ST_WB;
                     wb_valid <= 1'b1;
                     wb_int   <= is_cmp_q;
                  end else begin
                     cnt <= cnt - 5'd1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef FP_PERF_CNT_EN
   // Event counters; a flushed op was still issued, so it stays counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued  <= 32'd0;
         perf_busy    <= 32'd0;
         perf_illegal <= 16'd0;
      end else begin
         if (in_valid && in_ready && !flush && !dec_illegal) perf_issued <= perf_issued + 32'd1;
         if (in_valid && in_ready && !flush && dec_illegal) perf_illegal <= perf_illegal + 16'd1;
         if (busy) perf_busy <= perf_busy + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Self-checking bench for fp_issue_ctrl: directed cases plus randomized
// instruction streams scored against a behavioural decode/timing model.
// Build with FP_PERF_CNT_EN defined to also cover the performance counters.
module tb_fp_issue_ctrl;

   localparam int LAT_ADD  = 3;
   localparam int LAT_MUL  = 4;
   localparam int LAT_DIV  = 12;
   localparam int LAT_SQRT = 12;
   localparam int LAT_CMP  = 1;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        flush;
   logic        fpu_start;
   logic [3:0]  fpu_op;
   logic [4:0]  fpu_rs1;
   logic [4:0]  fpu_rs2;
   logic [2:0]  fpu_rm;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_int;
   logic        illegal;
   logic        busy;
   logic [1:0]  dbg_state;
`ifdef FP_PERF_CNT_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_busy;
   logic [15:0] perf_illegal;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_on = 0;

   // Expected events, each tagged with the cycle in which it must be visible.
   logic [48:0] exp_start_q[$];  // {cycle, op, rs1, rs2, rm}
   logic [37:0] exp_wb_q[$];     // {cycle, rd, int}
   logic [31:0] exp_ill_q[$];    // {cycle}
   int busy_from = -1;
   int busy_to   = -2;
   int unsigned m_issued  = 0;
   int unsigned m_busy    = 0;
   int unsigned m_illegal = 0;

   fp_issue_ctrl #(
      .LAT_ADD (LAT_ADD), .LAT_MUL (LAT_MUL), .LAT_DIV (LAT_DIV),
      .LAT_SQRT(LAT_SQRT), .LAT_CMP (LAT_CMP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .instr    (instr),
      .flush    (flush),
      .fpu_start(fpu_start),
      .fpu_op   (fpu_op),
      .fpu_rs1  (fpu_rs1),
      .fpu_rs2  (fpu_rs2),
      .fpu_rm   (fpu_rm),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_int   (wb_int),
      .illegal  (illegal),
      .busy     (busy),
      .dbg_state(dbg_state)
`ifdef FP_PERF_CNT_EN
      ,
      .perf_issued (perf_issued),
      .perf_busy   (perf_busy),
      .perf_illegal(perf_illegal)
`endif
   );

   // Clock and edge counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference decode straight from the instruction-set rules.
   task automatic ref_decode(input logic [31:0] ins, output int op, output bit legal,
                             output bit cmp, output int lat);
      logic [6:0] f7;
      logic [2:0] f3;
      bit         rm_ok;
      f7 = ins[31:25];
      f3 = ins[14:12];
      rm_ok = !(f3 == 3'd5 || f3 == 3'd6);
      op = 0; legal = 0; cmp = 0; lat = 0;
      if (ins[6:0] == 7'h53) begin
         if (f7 == 7'h00)      begin op = 1; lat = LAT_ADD;  legal = rm_ok; end
         else if (f7 == 7'h04) begin op = 2; lat = LAT_ADD;  legal = rm_ok; end
         else if (f7 == 7'h08) begin op = 3; lat = LAT_MUL;  legal = rm_ok; end
         else if (f7 == 7'h0C) begin op = 4; lat = LAT_DIV;  legal = rm_ok; end
         else if (f7 == 7'h2C) begin op = 5; lat = LAT_SQRT; legal = rm_ok && (ins[24:20] == 5'd0); end
         else if (f7 == 7'h14 && f3 <= 3'd1) begin op = 6 + int'(f3); lat = LAT_CMP; legal = 1; end
         else if (f7 == 7'h50 && f3 <= 3'd2) begin
            op = (f3 == 3'd2) ? 8 : (f3 == 3'd1) ? 9 : 10;
            lat = LAT_CMP; legal = 1; cmp = 1;
         end
      end
   endtask

   // Called just after the accepting edge (cyc == k).
   task automatic model_accept(input logic [31:0] ins);
      int op, lat;
      bit legal, cmp;
      ref_decode(ins, op, legal, cmp, lat);
      if (legal) begin
         exp_start_q.push_back({32'(cyc + 1), 4'(op), ins[19:15], ins[24:20], ins[14:12]});
         exp_wb_q.push_back({32'(cyc + 1 + lat), ins[11:7], cmp});
         busy_from = cyc;
         busy_to   = cyc + lat;
         m_issued++;
      end else begin
         exp_ill_q.push_back(32'(cyc));
         m_illegal++;
      end
   endtask

   // Called just after the flushing edge: nothing may appear from this cycle on.
   task automatic model_flush();
      logic [48:0] ts[$];
      logic [37:0] tw[$];
      logic [31:0] ti[$];
      foreach (exp_start_q[i]) if (int'(exp_start_q[i][48:17]) < cyc) ts.push_back(exp_start_q[i]);
      foreach (exp_wb_q[i])    if (int'(exp_wb_q[i][37:6]) < cyc)     tw.push_back(exp_wb_q[i]);
      foreach (exp_ill_q[i])   if (int'(exp_ill_q[i]) < cyc)          ti.push_back(exp_ill_q[i]);
      exp_start_q = ts;
      exp_wb_q    = tw;
      exp_ill_q   = ti;
      if (busy_to >= cyc) busy_to = cyc - 1;
   endtask

   task automatic model_reset();
      exp_start_q.delete();
      exp_wb_q.delete();
      exp_ill_q.delete();
      busy_from = -1;
      busy_to   = -2;
      m_issued  = 0;
      m_busy    = 0;
      m_illegal = 0;
   endtask

   // Monitor: compares handshake/busy every cycle and pops on every DUT event.
   always @(negedge clk) begin
      if (mon_on) begin
         bit exp_busy;
         exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
         check("busy", 64'(busy), 64'(exp_busy));
         check("in_ready", 64'(in_ready), 64'(!exp_busy));
         if (exp_busy) m_busy++;
         if (fpu_start) begin
            if (exp_start_q.size() == 0) check("fpu_start_unexpected", 1, 0);
            else begin
               logic [48:0] e;
               e = exp_start_q.pop_front();
               check("start_cycle", 64'(cyc), 64'(e[48:17]));
               check("fpu_op", 64'(fpu_op), 64'(e[16:13]));
               check("fpu_rs1", 64'(fpu_rs1), 64'(e[12:8]));
               check("fpu_rs2", 64'(fpu_rs2), 64'(e[7:3]));
               check("fpu_rm", 64'(fpu_rm), 64'(e[2:0]));
            end
         end
         if (wb_valid) begin
            if (exp_wb_q.size() == 0) check("wb_valid_unexpected", 1, 0);
            else begin
               logic [37:0] e;
               e = exp_wb_q.pop_front();
               check("wb_cycle", 64'(cyc), 64'(e[37:6]));
               check("wb_rd", 64'(wb_rd), 64'(e[5:1]));
               check("wb_int", 64'(wb_int), 64'(e[0]));
            end
         end else if (wb_int) check("wb_int_without_valid", 1, 0);
         if (illegal) begin
            if (exp_ill_q.size() == 0) check("illegal_unexpected", 1, 0);
            else check("illegal_cycle", 64'(cyc), 64'(exp_ill_q.pop_front()));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one instruction and wait (bounded) for it to be taken.
   task automatic offer(input logic [31:0] ins);
      bit done;
      done = 0;
      in_valid = 1'b1;
      instr    = ins;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            model_accept(ins);
            done = 1;
         end
      end
      in_valid = 1'b0;
      instr    = $urandom;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout cycle %0d: got no accept expected accept", cyc);
      end
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      model_flush();
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", 64'(in_ready), 1);
      check("rst_fpu_start", 64'(fpu_start), 0);
      check("rst_fpu_op", 64'(fpu_op), 0);
      check("rst_rs", 64'({fpu_rs1, fpu_rs2, fpu_rm}), 0);
      check("rst_wb", 64'({wb_valid, wb_rd, wb_int}), 0);
      check("rst_illegal", 64'(illegal), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_state", 64'(dbg_state), 0);
`ifdef FP_PERF_CNT_EN
      check("rst_perf", 64'({perf_issued, perf_busy, perf_illegal}), 0);
`endif
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [4:0]  rs2;
      int          kind;
      r    = $urandom;
      kind = $urandom_range(0, 9);
      f3   = r[14:12];
      rs2  = r[24:20];
      case (kind)
         0: f7 = 7'h00;
         1: f7 = 7'h04;
         2: f7 = 7'h08;
         3: f7 = 7'h0C;
         4: begin f7 = 7'h2C; if ($urandom_range(0, 1) == 1) rs2 = 5'd0; end
         5: begin f7 = 7'h14; f3 = 3'($urandom_range(0, 3)); end
         6: begin f7 = 7'h50; f3 = 3'($urandom_range(0, 3)); end
         7: f7 = r[31:25];
         default: f7 = 7'h50;
      endcase
      if (kind == 9) return r;
      return {f7, rs2, r[19:15], f3, r[11:7], 7'h53};
   endfunction

   initial begin
      logic [31:0] fadd, feq, fdiv, fmul, fsub, fmin, fsqrt;
      int k1, k2;
      fadd  = 32'b0000000_01000_10001_000_01111_1010011;
      feq   = 32'b1010000_11011_10011_010_01000_1010011;
      fdiv  = 32'b0001100_11010_10011_001_01001_1010011;
      fmul  = 32'b0001000_00011_00010_111_00100_1010011;
      fsub  = 32'b0000100_00110_00101_010_00111_1010011;
      fmin  = 32'b0010100_01010_01001_000_01011_1010011;
      fsqrt = 32'b0101100_00000_00100_011_00101_1010011;

      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; instr = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      idle(1);
      model_reset();
      mon_on = 1;

      // FADD: start one cycle after accept, result LAT_ADD cycles later.
      offer(fadd);
      repeat (2) @(negedge clk);
      check("fadd_start", 64'(fpu_start), 1);
      check("fadd_op", 64'(fpu_op), 1);
      check("fadd_rs1_rs2", 64'({fpu_rs1, fpu_rs2}), 64'({5'd17, 5'd8}));
      repeat (3) @(negedge clk);
      check("fadd_wb", 64'({wb_valid, wb_rd, wb_int}), 64'({1'b1, 5'd15, 1'b0}));
      idle(2);

      // FEQ: single-cycle latency, integer writeback.
      offer(feq);
      repeat (2) @(negedge clk);
      check("feq_start_op", 64'({fpu_start, fpu_op}), 64'({1'b1, 4'd8}));
      @(negedge clk);
      check("feq_wb", 64'({wb_valid, wb_rd, wb_int}), 64'({1'b1, 5'd8, 1'b1}));
      idle(2);

      // Illegal encodings.
      offer(32'h00000013);
      offer(32'b0101100_00101_00010_000_00011_1010011);
      offer(32'b0000000_00010_00001_101_00011_1010011);
      idle(3);

      // FDIV flushed five cycles after its start, then FMUL completes normally.
      offer(fdiv);
      idle(6);
      do_flush();
      @(negedge clk);
      check("flush_state", 64'(dbg_state), 0);
      check("flush_fields", 64'({fpu_op, fpu_rs1, fpu_rs2, fpu_rm}), 0);
      idle(1);
      offer(fmul);
      repeat (2) @(negedge clk);
      check("fmul_start", 64'(fpu_start), 1);
      repeat (4) @(negedge clk);
      check("fmul_wb", 64'(wb_valid), 1);
      idle(2);

      // Back-to-back: second accept lands in the WB cycle of the first.
      offer(fsub);
      k1 = cyc;
      offer(fmin);
      k2 = cyc;
      check("b2b_spacing", 64'(k2 - k1), 64'(LAT_ADD + 2));
      idle(4);

      // Reset in the middle of an FSQRT.
      offer(fsqrt);
      idle(4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset_outputs();
      idle(1);

      // Flush in IDLE blocks an offered instruction for that cycle.
      flush = 1'b1; in_valid = 1'b1; instr = fadd;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      model_flush();
      idle(3);

      // Randomized stream with occasional flushes.
      repeat (150) begin
         offer(gen_instr());
         if ($urandom_range(0, 7) == 0) begin
            idle($urandom_range(0, 6));
            do_flush();
         end else begin
            idle($urandom_range(0, 3));
         end
      end

      idle(20);
      check("start_q_empty", 64'(exp_start_q.size()), 0);
      check("wb_q_empty", 64'(exp_wb_q.size()), 0);
      check("ill_q_empty", 64'(exp_ill_q.size()), 0);
`ifdef FP_PERF_CNT_EN
      @(negedge clk);
      check("perf_issued", 64'(perf_issued), 64'(m_issued));
      check("perf_busy", 64'(perf_busy), 64'(m_busy));
      check("perf_illegal", 64'(perf_illegal), 64'(m_illegal[15:0]));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog cycle %0d: got no end expected end", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
